// File: rtl/pwm_gate_guard_if.sv
// Purpose : signal bundle between the CPU/PWM-accelerator side and pwm_gate_guard.
// Latency : none (wires only).
// Backpressure: none; all signals are levels or one-cycle pulses.
// Ports (master = CPU/accelerator side, slave = guard):
//   arm, clear, pwm_in, fault_in, min_pulse, cooldown        master -> slave
//   gate_out, fault_out, state, fault_cause, st_count        slave -> master
interface pwm_gate_guard_if #(
  parameter int CNT_W = 16
);
  logic             arm;
  logic             clear;
  logic [7:0]       pwm_in;
  logic             fault_in;
  logic [CNT_W-1:0] min_pulse;
  logic [CNT_W-1:0] cooldown;
  logic [7:0]       gate_out;
  logic             fault_out;
  logic [1:0]       state;
  logic [1:0]       fault_cause;
  logic [7:0]       st_count;

  modport master (
    output arm, clear, pwm_in, fault_in, min_pulse, cooldown,
    input  gate_out, fault_out, state, fault_cause, st_count
  );

  modport slave (
    input  arm, clear, pwm_in, fault_in, min_pulse, cooldown,
    output gate_out, fault_out, state, fault_cause, st_count
  );
endinterface

// File: rtl/pwm_gate_guard.sv
// Purpose : gate-drive protection between PWM accelerator and gate drivers (interlock, min pulse,
//           shoot-through detect, external trip, latched fault with clear + cooldown + re-arm).
// Latency : pwm_in -> gate_out 1 cycle unconstrained; fault_in -> gates low <= 3 edges (more with filter).
// Backpressure: none; gates are forced low on fault, fault_out feeds back to the accelerator.
// Ports: clk, rst_n (async active-low); gg (slave modport of pwm_gate_guard_if) carrying
//   arm/clear/pwm_in/fault_in/min_pulse/cooldown in and gate_out/fault_out/state/fault_cause/st_count out.
// Optional feature macro: PWM_FAULT_FILTER_EN -- trip needs FILTER_LEN consecutive synchronised
//   fault_in samples; when undefined a single high synchronised sample trips.
module pwm_gate_guard #(
  parameter int CNT_W      = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_gate_guard_if.slave gg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2,
    ST_COOL  = 2'd3
  } state_e;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("pwm_gate_guard: FILTER_LEN must be at least 1");
  end

  state_e                 state_q, state_d;
  logic                   arm_prev_q;
  logic                   sync1_q, fsync_q;
  logic [7:0]             gate_q, gate_d;
  logic [7:0][CNT_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]       cd_q, cd_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             st_cnt_q, st_cnt_d;

  logic                   trip;
  logic                   shoot;
  logic [7:0]             rise_req;
  logic [CNT_W-1:0]       pulse_load;

  // ---------------------------------------------------------------------------
  // Trip qualification
  // ---------------------------------------------------------------------------
`ifdef PWM_FAULT_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_q, filt_d;

  // Counts consecutive high synchronised samples, saturating at FILTER_LEN.
  always_comb begin
    filt_d = filt_q;
    if (!fsync_q) begin
      filt_d = '0;
    end else if (filt_q != FW'(FILTER_LEN)) begin
      filt_d = filt_q + FW'(1);
    end
  end

  // The current sample is the FILTER_LEN-th high one when FILTER_LEN-1 were already counted.
  assign trip = fsync_q && (filt_q >= FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  assign trip = fsync_q;
`endif

  // Shoot-through is judged on the raw PWM inputs, not on the gated outputs.
  assign shoot = (gg.pwm_in[0] & gg.pwm_in[1]) | (gg.pwm_in[2] & gg.pwm_in[3]) |
                 (gg.pwm_in[4] & gg.pwm_in[5]) | (gg.pwm_in[6] & gg.pwm_in[7]);

  // A counter loaded with N-1 holds the new level for exactly N cycles; 0 and 1 both mean no hold.
  assign pulse_load = (gg.min_pulse > CNT_W'(1)) ? (gg.min_pulse - CNT_W'(1)) : '0;

  // ---------------------------------------------------------------------------
  // FSM next state, cooldown counter, fault cause, shoot-through counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    cause_d  = cause_q;
    st_cnt_d = st_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gg.arm && !arm_prev_q && !trip) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (trip || shoot) begin
          state_d = ST_FAULT;
          cause_d = cause_q | {shoot, trip};
        end else if (!gg.arm) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (gg.clear && !trip) begin
          state_d = ST_COOL;
          cause_d = 2'b00;
          cd_d    = gg.cooldown;
        end else begin
          cause_d = cause_q | {shoot, trip};
        end
      end
      ST_COOL: begin
        if (trip || shoot) begin
          state_d = ST_FAULT;
          cause_d = cause_q | {shoot, trip};
        end else if (cd_q <= CNT_W'(1)) begin
          // Loaded value N gives N cycles in COOLDOWN (0 behaves like 1).
          state_d = ST_IDLE;
          cd_d    = '0;
        end else begin
          cd_d = cd_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (shoot && (st_cnt_q != 8'hFF)) begin
      st_cnt_d = st_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel gate path: interlock + minimum pulse width
  // ---------------------------------------------------------------------------
  always_comb begin
    gate_d   = '0;
    pc_d     = '0;
    rise_req = '0;

    // A channel wants to rise when its hold has expired and its PWM input asks for it.
    for (int c = 0; c < 8; c++) begin
      rise_req[c] = gg.pwm_in[c] & ~gate_q[c] & (pc_q[c] == '0);
    end

    for (int c = 0; c < 8; c++) begin
      if (state_d != ST_RUN) begin
        // Leaving or outside RUN: gates off at once, min-pulse holds abandoned.
        gate_d[c] = 1'b0;
        pc_d[c]   = '0;
      end else if (pc_q[c] != '0) begin
        gate_d[c] = gate_q[c];
        pc_d[c]   = pc_q[c] - CNT_W'(1);
      end else begin
        if (rise_req[c]) begin
          // Blocked while the partner is on or rising on this same edge; a simultaneous
          // request from both sides leaves both off.
          gate_d[c] = ~(gate_q[c ^ 1] | rise_req[c ^ 1]);
        end else begin
          gate_d[c] = gg.pwm_in[c];
        end
        pc_d[c] = (gate_d[c] != gate_q[c]) ? pulse_load : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_prev_q <= 1'b0;
      sync1_q    <= 1'b0;
      fsync_q    <= 1'b0;
      gate_q     <= '0;
      pc_q       <= '0;
      cd_q       <= '0;
      cause_q    <= 2'b00;
      st_cnt_q   <= '0;
    end else begin
      arm_prev_q <= gg.arm;
      sync1_q    <= gg.fault_in;
      fsync_q    <= sync1_q;
      gate_q     <= gate_d;
      pc_q       <= pc_d;
      cd_q       <= cd_d;
      cause_q    <= cause_d;
      st_cnt_q   <= st_cnt_d;
    end
  end

  assign gg.gate_out    = gate_q;
  assign gg.fault_out   = (state_q == ST_FAULT);
  assign gg.state       = state_q;
  assign gg.fault_cause = cause_q;
  assign gg.st_count    = st_cnt_q;

endmodule
